// File: rtl/lbist_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_pkg
//  Purpose  : Shared types and constants for the LBIST sequencer: the FSM
//             state encoding, the bundle of Moore strobes and a helper that
//             decodes a state into its strobe values.
//  Revision : 1.0  initial release
// ============================================================================
package lbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } lbist_state_e;

    // Fault-free signature used when the integrator does not supply one.
    localparam logic [31:0] LBIST_DEFAULT_GOLDEN_SIG = 32'h0;

    typedef struct packed {
        logic lfsr_load;
        logic misr_clr;
        logic lfsr_en;
        logic misr_en;
        logic scan_en;
        logic capture;
        logic busy;
        logic test_over;
    } lbist_strobes_t;

    // Strobe values for a state. misr_armed gates compaction during SHIFT:
    // the very first scan-out carries uninitialised flop contents.
    function automatic lbist_strobes_t state_strobes(input lbist_state_e st,
                                                     input logic         misr_armed);
        lbist_strobes_t s;
        s = '0;
        case (st)
            ST_INIT: begin
                s.lfsr_load = 1'b1;
                s.misr_clr  = 1'b1;
                s.busy      = 1'b1;
            end
            ST_SHIFT: begin
                s.scan_en   = 1'b1;
                s.lfsr_en   = 1'b1;
                s.misr_en   = misr_armed;
                s.busy      = 1'b1;
            end
            ST_CAPTURE: begin
                s.capture   = 1'b1;
                s.busy      = 1'b1;
            end
            ST_UNLOAD: begin
                s.scan_en   = 1'b1;
                s.misr_en   = 1'b1;
                s.busy      = 1'b1;
            end
            ST_COMPARE: begin
                s.busy      = 1'b1;
            end
            ST_DONE: begin
                s.test_over = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbist_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_sequencer_if
//  Purpose  : Bundle of the LBIST sequencer control/status signals.
//  Ports    : test_mode_i, start_i, misr_sig_i  - requests and MISR value
//             lfsr_load_o .. capture_o          - strobes to LFSR/MISR/core
//             busy_o, test_over_o, go_nogo_o    - status and result
//  Modports : master - the sequencer; slave - the test environment
//  Revision : 1.0  initial release
// ============================================================================
interface lbist_sequencer_if #(
    parameter int SIG_W = 32
) ();
    logic             test_mode_i;
    logic             start_i;
    logic [SIG_W-1:0] misr_sig_i;
    logic             lfsr_load_o;
    logic             misr_clr_o;
    logic             lfsr_en_o;
    logic             misr_en_o;
    logic             scan_en_o;
    logic             capture_o;
    logic             busy_o;
    logic             test_over_o;
    logic             go_nogo_o;

    modport master (
        input  test_mode_i, start_i, misr_sig_i,
        output lfsr_load_o, misr_clr_o, lfsr_en_o, misr_en_o, scan_en_o,
               capture_o, busy_o, test_over_o, go_nogo_o
    );

    modport slave (
        output test_mode_i, start_i, misr_sig_i,
        input  lfsr_load_o, misr_clr_o, lfsr_en_o, misr_en_o, scan_en_o,
               capture_o, busy_o, test_over_o, go_nogo_o
    );
endinterface
`default_nettype wire

// File: rtl/lbist_sequencer_cycle_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_cycle_cnt
//  Purpose  : Up-counter with synchronous load-to-zero, count enable and a
//             terminal-count flag. Saturates at TERMINAL instead of wrapping.
//  Ports    : clk, rst_n (async, active-low)
//             i_load - clear count to zero (priority over i_en)
//             i_en   - increment by one
//             o_tc   - count equals TERMINAL
//  Revision : 1.0  initial release
// ============================================================================
module lbist_cycle_cnt #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_load,
    input  wire logic i_en,
    output logic      o_tc
);
    localparam logic [WIDTH-1:0] c_terminal = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_terminal)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_tc = (r_count == c_terminal);
endmodule
`default_nettype wire

// File: rtl/lbist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lbist_sequencer
//  Purpose  : Logic-BIST controller. Seeds the LFSR, runs N_PATTERNS
//             shift/capture rounds of SHIFT_LEN cycles, unloads the last
//             response into the MISR and compares the signature against
//             GOLDEN_SIG. LFSR and MISR datapaths live outside.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - lbist_sequencer_if.master (requests, strobes, status)
//  Revision : 1.0  initial release
// ============================================================================
module lbist_sequencer
    import lbist_pkg::*;
#(
    parameter int               SHIFT_LEN  = 64,
    parameter int               N_PATTERNS = 1024,
    parameter int               SIG_W      = 32,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(LBIST_DEFAULT_GOLDEN_SIG)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    lbist_sequencer_if.master  bus
);
    localparam int c_shift_w = $clog2(SHIFT_LEN);
    localparam int c_pat_w   = $clog2(N_PATTERNS + 1);

    lbist_state_e   r_state;
    lbist_state_e   w_next;
    lbist_strobes_t r_strb;
    lbist_strobes_t w_strb;
    logic           r_go_nogo;
    logic           w_go_nogo;

    logic w_shift_en;
    logic w_shift_load;
    logic w_shift_tc;
    logic w_pat_load;
    logic w_pat_en;
    logic w_pat_tc;
    logic w_misr_armed;

    // Shift counter runs through SHIFT and UNLOAD and is parked at zero
    // everywhere else, so every shift window starts from a clean count.
    assign w_shift_en   = (r_state == ST_SHIFT) || (r_state == ST_UNLOAD);
    assign w_shift_load = !w_shift_en;

    // The pattern count steps on the last shift cycle, so while in CAPTURE
    // it already includes the pattern being captured; the CAPTURE exit
    // decision then simply tests for N_PATTERNS.
    assign w_pat_load = (r_state == ST_IDLE) || (r_state == ST_INIT);
    assign w_pat_en   = (r_state == ST_SHIFT) && w_shift_tc;

    lbist_cycle_cnt #(
        .WIDTH    (c_shift_w),
        .TERMINAL (SHIFT_LEN - 1)
    ) u_shift_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_shift_load),
        .i_en   (w_shift_en),
        .o_tc   (w_shift_tc)
    );

    lbist_cycle_cnt #(
        .WIDTH    (c_pat_w),
        .TERMINAL (N_PATTERNS)
    ) u_pat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_pat_load),
        .i_en   (w_pat_en),
        .o_tc   (w_pat_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.test_mode_i && bus.start_i) w_next = ST_INIT;
            ST_INIT:    w_next = ST_SHIFT;
            ST_SHIFT:   if (w_shift_tc) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = w_pat_tc ? ST_UNLOAD : ST_SHIFT;
            ST_UNLOAD:  if (w_shift_tc) w_next = ST_COMPARE;
            ST_COMPARE: w_next = ST_DONE;
            ST_DONE:    if (!bus.start_i) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        // Dropping test mode wins over every other transition.
        if (!bus.test_mode_i) begin
            w_next = ST_IDLE;
        end
    end

    // Compaction is armed once any capture has happened: either we are
    // leaving CAPTURE now, or the current SHIFT window is already compacting.
    assign w_misr_armed = (r_state == ST_CAPTURE) || r_strb.misr_en;

    assign w_strb = state_strobes(w_next, w_misr_armed);

    // Result is only meaningful in DONE; it is zero in every other state.
    always_comb begin
        w_go_nogo = 1'b0;
        if (w_next == ST_DONE) begin
            w_go_nogo = (r_state == ST_COMPARE) ? (bus.misr_sig_i == GOLDEN_SIG)
                                                : r_go_nogo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_strb    <= '0;
            r_go_nogo <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_strb    <= w_strb;
            r_go_nogo <= w_go_nogo;
        end
    end

    assign bus.lfsr_load_o = r_strb.lfsr_load;
    assign bus.misr_clr_o  = r_strb.misr_clr;
    assign bus.lfsr_en_o   = r_strb.lfsr_en;
    assign bus.misr_en_o   = r_strb.misr_en;
    assign bus.scan_en_o   = r_strb.scan_en;
    assign bus.capture_o   = r_strb.capture;
    assign bus.busy_o      = r_strb.busy;
    assign bus.test_over_o = r_strb.test_over;
    assign bus.go_nogo_o   = r_go_nogo;
endmodule
`default_nettype wire

// File: tb/tb_lbist_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbist_sequencer
//  Purpose  : Self-checking bench for lbist_sequencer (SHIFT_LEN=4,
//             N_PATTERNS=3, GOLDEN_SIG=32'hA5A5_1234). A cycle-schedule
//             reference model predicts every output on every clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lbist_sequencer;
    localparam int          S   = 4;
    localparam int          N   = 3;
    localparam int          W   = 32;
    localparam logic [31:0] G   = 32'hA5A5_1234;
    localparam int          RUN = 1 + N * (S + 1) + S + 1;   // 21

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lbist_sequencer_if #(.SIG_W(W)) bus ();

    lbist_sequencer #(
        .SHIFT_LEN  (S),
        .N_PATTERNS (N),
        .SIG_W      (W),
        .GOLDEN_SIG (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position in the run schedule, counted in clock edges
    // after the edge that sampled the start request (0 = seed/clear cycle).
    bit m_active = 1'b0;
    int m_t      = 0;
    bit m_go     = 1'b0;

    function automatic logic [8:0] outs();
        return {bus.lfsr_load_o, bus.misr_clr_o, bus.lfsr_en_o, bus.misr_en_o,
                bus.scan_en_o, bus.capture_o, bus.busy_o, bus.test_over_o,
                bus.go_nogo_o};
    endfunction

    function automatic logic [8:0] expect_outs();
        logic ld, clr, len, men, sen, cap, bsy, tov, go;
        int u;
        {ld, clr, len, men, sen, cap, bsy, tov, go} = 9'b0;
        if (m_active) begin
            if (m_t == 0) begin
                ld = 1; clr = 1; bsy = 1;
            end else if (m_t <= N * (S + 1)) begin
                u   = m_t - 1;
                bsy = 1;
                if ((u % (S + 1)) < S) begin
                    sen = 1; len = 1; men = ((u / (S + 1)) > 0);
                end else begin
                    cap = 1;
                end
            end else if (m_t < RUN - 1) begin
                sen = 1; men = 1; bsy = 1;
            end else if (m_t == RUN - 1) begin
                bsy = 1;
            end else begin
                tov = 1; go = m_go;
            end
        end
        return {ld, clr, len, men, sen, cap, bsy, tov, go};
    endfunction

    task automatic model_step(input bit rv, input bit tm, input bit st,
                              input logic [31:0] mv);
        if (!rv) begin
            m_active = 0;
        end else if (!m_active) begin
            if (tm && st) begin
                m_active = 1; m_t = 0; m_go = 0;
            end
        end else if (!tm) begin
            m_active = 0;
        end else if (m_t >= RUN) begin
            if (!st) m_active = 0;
        end else begin
            if (m_t == RUN - 1) m_go = (mv == G);
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample the inputs the DUT will see, step the model, then
    // compare all outputs shortly after the edge.
    task automatic tick(input string tag);
        bit rv, tm, st;
        logic [31:0] mv;
        rv = rst_n; tm = bus.test_mode_i; st = bus.start_i; mv = bus.misr_sig_i;
        @(posedge clk);
        model_step(rv, tm, st, mv);
        #1;
        check(tag, outs(), expect_outs());
    endtask

    task automatic async_reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        m_active = 0;
        check(tag, outs(), 9'b0);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_to_done(input logic [31:0] misr, input bit drop_start,
                               output int lat, output int cap, output int scn,
                               output int men, output int ld);
        bus.test_mode_i = 1'b1;
        bus.start_i     = 1'b1;
        bus.misr_sig_i  = misr;
        lat = -1; cap = 0; scn = 0; men = 0; ld = 0;
        for (int n = 0; n < 60 && lat < 0; n++) begin
            tick("run_cycle");
            if (drop_start) bus.start_i = 1'b0;
            cap += int'(bus.capture_o);
            scn += int'(bus.scan_en_o);
            men += int'(bus.misr_en_o);
            ld  += int'(bus.lfsr_load_o);
            if (bus.test_over_o) lat = n;
        end
    endtask

    typedef struct {
        logic [31:0] misr;
        bit          drop;
        int          lat;
        bit          go;
        int          cap;
        int          scn;
        int          men;
        int          ld;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cap, scn, men, ld, overs;
        vecs[0] = '{misr: 32'hA5A5_1234, drop: 1'b0, lat: 21, go: 1'b1,
                    cap: 3, scn: 16, men: 12, ld: 1};
        vecs[1] = '{misr: 32'hA5A5_1235, drop: 1'b0, lat: 21, go: 1'b0,
                    cap: 3, scn: 16, men: 12, ld: 1};
        vecs[2] = '{misr: 32'hA5A5_1234, drop: 1'b1, lat: 21, go: 1'b1,
                    cap: 3, scn: 16, men: 12, ld: 1};

        bus.test_mode_i = 1'b0;
        bus.start_i     = 1'b0;
        bus.misr_sig_i  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_outs", outs(), 9'b0);
        tick("in_reset");
        #3 rst_n = 1'b1;

        // Test mode alone must not start a run.
        bus.test_mode_i = 1'b1;
        for (int i = 0; i < 3; i++) tick("idle_no_start");

        // Table-driven full runs.
        foreach (vecs[k]) begin
            run_to_done(vecs[k].misr, vecs[k].drop, lat, cap, scn, men, ld);
            check_int("latency", lat, vecs[k].lat);
            check_int("go_nogo", int'(bus.go_nogo_o), int'(vecs[k].go));
            check_int("capture_pulses", cap, vecs[k].cap);
            check_int("scan_en_cycles", scn, vecs[k].scn);
            check_int("misr_en_cycles", men, vecs[k].men);
            check_int("lfsr_load_pulses", ld, vecs[k].ld);
            if (!vecs[k].drop) begin
                for (int i = 0; i < 3; i++) begin
                    tick("done_hold");
                    check_int("done_hold_over", int'(bus.test_over_o), 1);
                end
            end
            bus.start_i = 1'b0;
            tick("done_exit");
            check_int("done_exit_over", int'(bus.test_over_o), 0);
        end

        // Abort during the second SHIFT window, then a clean re-run.
        bus.test_mode_i = 1'b1; bus.start_i = 1'b1; bus.misr_sig_i = G;
        for (int n = 0; n < 8; n++) tick("pre_abort");
        bus.test_mode_i = 1'b0;
        tick("abort");
        check("abort_outs", outs(), 9'b0);
        run_to_done(G, 1'b0, lat, cap, scn, men, ld);
        check_int("rerun_latency", lat, RUN);
        bus.start_i = 1'b0;
        tick("rerun_exit");

        // Asynchronous reset while unloading.
        bus.test_mode_i = 1'b1; bus.start_i = 1'b1; bus.misr_sig_i = G;
        for (int n = 0; n < 18; n++) tick("pre_reset");
        check_int("in_unload_scan", int'(bus.scan_en_o), 1);
        bus.start_i = 1'b0;
        async_reset_pulse("reset_in_unload");
        overs = 0;
        for (int n = 0; n < 25; n++) begin
            tick("post_reset_idle");
            overs += int'(bus.test_over_o);
        end
        check_int("no_over_after_reset", overs, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.test_mode_i = ($urandom_range(0, 24) != 0);
            bus.start_i     = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       bus.misr_sig_i = G;
                1:       bus.misr_sig_i = G ^ (32'h1 << $urandom_range(0, 31));
                default: bus.misr_sig_i = $urandom;
            endcase
            if ($urandom_range(0, 199) == 0) async_reset_pulse("rand_reset");
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lbist_sequencer.md
LBIST_SEQUENCER -- requirements
Module: lbist_sequencer

Interface
REQ-001 SHALL have parameter SHIFT_LEN, default 64; scan chain length in shift cycles (>=2).
REQ-002 SHALL have parameter N_PATTERNS, default 1024; number of capture patterns (>=1).
REQ-003 SHALL have parameter SIG_W, default 32; MISR signature width.
REQ-004 SHALL have parameter GOLDEN_SIG, default 32'h0; expected fault-free signature, SIG_W bits.
REQ-005 SHALL have port clk  input  1  clock, all state updated on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port test_mode_i  input  1  enables BIST; low forces IDLE.
REQ-008 SHALL have port start_i  input  1  level request to run BIST.
REQ-009 SHALL have port misr_sig_i  input  SIG_W  current MISR signature.
REQ-010 SHALL have port lfsr_load_o  output  1  load seed into LFSR.
REQ-011 SHALL have port misr_clr_o  output  1  clear MISR.
REQ-012 SHALL have port lfsr_en_o  output  1  advance LFSR.
REQ-013 SHALL have port misr_en_o  output  1  compact scan-out into MISR.
REQ-014 SHALL have port scan_en_o  output  1  scan shift enable to core.
REQ-015 SHALL have port capture_o  output  1  one-cycle functional capture pulse.
REQ-016 SHALL have port busy_o  output  1  high in any state except IDLE and DONE.
REQ-017 SHALL have port test_over_o  output  1  BIST finished, result valid.
REQ-018 SHALL have port go_nogo_o  output  1  1 = signature matched GOLDEN_SIG.

Function
REQ-019 SHALL implement FSM states IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE; all outputs Moore, registered state.
REQ-020 IDLE -> INIT when test_mode_i=1 and start_i=1 sampled; otherwise stay.
REQ-021 INIT: one cycle, lfsr_load_o=1, misr_clr_o=1, clears shift and pattern counters; -> SHIFT.
REQ-022 SHIFT: exactly SHIFT_LEN cycles, scan_en_o=1, lfsr_en_o=1, misr_en_o=1 only when pattern count >0 (first unload is uninitialised); -> CAPTURE.
REQ-023 CAPTURE: one cycle, scan_en_o=0, capture_o=1, pattern count +1; -> SHIFT if count<N_PATTERNS else UNLOAD.
REQ-024 UNLOAD: SHIFT_LEN cycles, scan_en_o=1, misr_en_o=1, lfsr_en_o=0; -> COMPARE.
REQ-025 COMPARE: one cycle, registers go_nogo = (misr_sig_i == GOLDEN_SIG); -> DONE.
REQ-026 DONE: test_over_o=1, go_nogo_o holds result; -> IDLE when start_i=0 or test_mode_i=0.
REQ-027 test_over_o SHALL rise exactly 1 + N_PATTERNS*(SHIFT_LEN+1) + SHIFT_LEN + 1 cycles after the edge sampling start.
REQ-028 test_mode_i=0 in any non-IDLE state SHALL abort to IDLE next cycle, clear go_nogo_o and test_over_o; abort priority over all transitions.
REQ-029 start_i deassertion during a run SHALL be ignored (run completes).
REQ-030 Shift counter width $clog2(SHIFT_LEN); pattern counter width $clog2(N_PATTERNS+1); no wrap before terminal value.
REQ-031 All strobe outputs SHALL be 0 in IDLE and DONE; lfsr_load_o/misr_clr_o/capture_o never concurrent with scan_en_o.

Reset
REQ-032 rst_n low SHALL force IDLE, counters 0, every output 0, asynchronously, including mid-run.
REQ-033 After rst_n release, no run SHALL start until start_i sampled high with test_mode_i high.

Structure
REQ-034 State enum and default GOLDEN_SIG constant SHALL live in shared package lbist_pkg.
REQ-035 Shift and pattern counting SHALL use one reusable sub-module lbist_cycle_cnt (load, enable, terminal-count flag).
REQ-036 LFSR and MISR datapaths SHALL be outside this block.

Verification (SHIFT_LEN=4, N_PATTERNS=3, GOLDEN_SIG=32'hA5A5_1234)
REQ-037 start=1, test_mode=1, misr_sig=32'hA5A5_1234 -> test_over_o rises 21 cycles later, go_nogo_o=1.
REQ-038 same, misr_sig=32'hA5A5_1235 -> test_over_o after 21 cycles, go_nogo_o=0.
REQ-039 count strobes over full run -> capture_o 3 pulses, scan_en_o 16 cycles, misr_en_o 12 cycles, lfsr_load_o 1 pulse.
REQ-040 test_mode_i dropped in 2nd SHIFT -> next cycle IDLE, all outputs 0; re-start runs full 21 cycles.
REQ-041 rst_n low during UNLOAD -> outputs 0 immediately, no test_over_o after release until new start.
REQ-042 In DONE, start_i held 1 -> stays DONE; start_i=0 -> IDLE, test_over_o=0 next cycle.
